// File: rtl/seg7_pkg.sv
// Shared constants, types and helpers for the gray-code switch / 7-segment display path.
package seg7_pkg;

    localparam int CLK_FREQ_HZ             = 27_000_000;
    localparam int DEBOUNCE_CYCLES_DEFAULT = CLK_FREQ_HZ / 1000;
    localparam int GRAY_W_MAX              = 32;

    typedef enum logic {
        STABLE   = 1'b0,
        SETTLING = 1'b1
    } filter_state_e;

    // Works for any width up to GRAY_W_MAX: zero-extended high bits convert to zeros.
    function automatic logic [GRAY_W_MAX-1:0] gray2bin(input logic [GRAY_W_MAX-1:0] g);
        logic [GRAY_W_MAX-1:0] b;
        b[GRAY_W_MAX-1] = g[GRAY_W_MAX-1];
        for (int i = GRAY_W_MAX - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/debounce_filter.sv
// Two-flop synchroniser followed by a bundle debounce filter that commits a value
// only after it has been seen unchanged for CYCLES consecutive clocks.
module debounce_filter
    import seg7_pkg::*;
#(
    parameter int WIDTH  = 1,
    parameter int CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] raw,
    output logic [WIDTH-1:0] stable,
    output logic             changed
);

    localparam int                CNT_W    = $clog2(CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CYCLES - 1);

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] synced;
    logic [WIDTH-1:0] candidate;
    logic [CNT_W-1:0] cnt;
    filter_state_e    state;

    // state always equals (candidate != stable); it is kept as a register so it can be observed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1     <= '0;
            synced    <= '0;
            candidate <= '0;
            stable    <= '0;
            cnt       <= '0;
            changed   <= 1'b0;
            state     <= STABLE;
        end else begin
            sync1   <= raw;
            synced  <= sync1;
            changed <= 1'b0;
            if (synced != candidate) begin
                candidate <= synced;
                cnt       <= '0;
                state     <= (synced == stable) ? STABLE : SETTLING;
            end else if (state == SETTLING) begin
                if (cnt == CNT_LAST) begin
                    stable  <= candidate;
                    cnt     <= '0;
                    changed <= 1'b1;
                    state   <= STABLE;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/gray_switch_reader.sv
// Debounced reader for the gray-code switch bank and digit-select button; presents a
// registered binary code, the button level and one-cycle event pulses to the display logic.
module gray_switch_reader
    import seg7_pkg::*;
#(
    parameter int N_BITS          = 4,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_BITS-1:0] gray_in,
    input  logic              btn_in,
    output logic [N_BITS-1:0] bin_out,
    output logic              data_valid,
    output logic              btn_level,
    output logic              btn_rise
);

    logic [N_BITS-1:0] sw_stable;
    logic              sw_changed;
    logic [0:0]        btn_stable;
    logic              btn_changed;

    debounce_filter #(
        .WIDTH  (N_BITS),
        .CYCLES (DEBOUNCE_CYCLES)
    ) u_sw_filter (
        .clk     (clk),
        .rst     (rst),
        .raw     (gray_in),
        .stable  (sw_stable),
        .changed (sw_changed)
    );

    debounce_filter #(
        .WIDTH  (1),
        .CYCLES (DEBOUNCE_CYCLES)
    ) u_btn_filter (
        .clk     (clk),
        .rst     (rst),
        .raw     (btn_in),
        .stable  (btn_stable),
        .changed (btn_changed)
    );

    // A commit always carries a value different from the previous stable one,
    // so the changed strobe alone qualifies data_valid and btn_rise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bin_out    <= '0;
            data_valid <= 1'b0;
            btn_level  <= 1'b0;
            btn_rise   <= 1'b0;
        end else begin
            bin_out    <= N_BITS'(gray2bin(GRAY_W_MAX'(sw_stable)));
            data_valid <= sw_changed;
            btn_level  <= btn_stable[0];
            btn_rise   <= btn_changed & btn_stable[0];
        end
    end

endmodule

// File: tb/tb_gray_switch_reader.sv
// Directed bench for gray_switch_reader with a short debounce window (4 clocks).
module tb_gray_switch_reader;
    import seg7_pkg::*;

    logic       clk;
    logic       rst;
    logic [3:0] gray_in;
    logic       btn_in;
    logic [3:0] bin_out;
    logic       data_valid;
    logic       btn_level;
    logic       btn_rise;

    int n_checks = 0;
    int n_errors = 0;
    int dv_cnt   = 0;
    int rise_cnt = 0;
    int dv_snap;
    int rise_snap;

    gray_switch_reader #(
        .N_BITS          (4),
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .gray_in    (gray_in),
        .btn_in     (btn_in),
        .bin_out    (bin_out),
        .data_valid (data_valid),
        .btn_level  (btn_level),
        .btn_rise   (btn_rise)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse counters sampled away from the active edge.
    always @(negedge clk) begin
        if (data_valid) dv_cnt++;
        if (btn_rise) rise_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst     = 1'b1;
        gray_in = 4'b0000;
        btn_in  = 1'b0;
        step(3);
        check("rst_bin", 32'(bin_out), 0);
        check("rst_dv", 32'(data_valid), 0);
        check("rst_level", 32'(btn_level), 0);
        check("rst_rise", 32'(btn_rise), 0);

        // Quiet inputs after reset: nothing should happen.
        rst = 1'b0;
        dv_snap = dv_cnt;
        rise_snap = rise_cnt;
        step(50);
        check("idle_bin", 32'(bin_out), 0);
        check("idle_dv_pulses", 32'(dv_cnt - dv_snap), 0);
        check("idle_rise_pulses", 32'(rise_cnt - rise_snap), 0);

        // 0000 -> 0110: binary 0100 appears on edge 8.
        dv_snap = dv_cnt;
        gray_in = 4'b0110;
        step(7);
        check("lat_dv_edge7", 32'(data_valid), 0);
        check("lat_bin_edge7", 32'(bin_out), 0);
        step(1);
        check("lat_dv_edge8", 32'(data_valid), 1);
        check("lat_bin_edge8", 32'(bin_out), 4);
        step(1);
        check("lat_dv_edge9", 32'(data_valid), 0);
        step(10);
        check("lat_dv_pulses", 32'(dv_cnt - dv_snap), 1);

        // Two-cycle glitch to 0111 must be filtered out.
        dv_snap = dv_cnt;
        gray_in = 4'b0111;
        step(2);
        gray_in = 4'b0110;
        step(20);
        check("glitch_bin", 32'(bin_out), 4);
        check("glitch_dv_pulses", 32'(dv_cnt - dv_snap), 0);

        // Bouncy button press, then hold.
        rise_snap = rise_cnt;
        btn_in = 1'b1; step(2);
        btn_in = 1'b0; step(1);
        btn_in = 1'b1; step(1);
        btn_in = 1'b0; step(2);
        btn_in = 1'b1; step(2);
        btn_in = 1'b0; step(1);
        btn_in = 1'b1;
        step(7);
        check("btn_level_edge7", 32'(btn_level), 0);
        step(1);
        check("btn_level_edge8", 32'(btn_level), 1);
        check("btn_rise_edge8", 32'(btn_rise), 1);
        step(10);
        check("btn_rise_pulses", 32'(rise_cnt - rise_snap), 1);

        // Release: level drops, no rise pulse.
        rise_snap = rise_cnt;
        btn_in = 1'b0;
        step(20);
        check("btn_release_level", 32'(btn_level), 0);
        check("btn_release_pulses", 32'(rise_cnt - rise_snap), 0);

        // Sweep all gray codes in gray-counting order; binary value equals the index.
        gray_in = 4'b0000;
        step(20);
        dv_snap = dv_cnt;
        for (int i = 0; i < 16; i++) begin
            gray_in = 4'(i ^ (i >> 1));
            step(20);
            check($sformatf("sweep_bin_%0d", i), 32'(bin_out), 32'(i));
        end
        check("sweep_dv_pulses", 32'(dv_cnt - dv_snap), 15);

        // Reset in the middle of settling toward 1000.
        gray_in = 4'b0110;
        step(20);
        check("pre_rst_bin", 32'(bin_out), 4);
        gray_in = 4'b1000;
        step(4);
        check("settling_state", 32'(dut.u_sw_filter.state), 32'(SETTLING));
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_bin", 32'(bin_out), 0);
        check("async_rst_dv", 32'(data_valid), 0);
        check("async_rst_state", 32'(dut.u_sw_filter.state), 32'(STABLE));
        step(2);
        rst = 1'b0;
        dv_snap = dv_cnt;
        step(7);
        check("post_rst_dv_edge7", 32'(data_valid), 0);
        check("post_rst_bin_edge7", 32'(bin_out), 0);
        step(1);
        check("post_rst_dv_edge8", 32'(data_valid), 1);
        check("post_rst_bin_edge8", 32'(bin_out), 15);
        step(10);
        check("post_rst_dv_pulses", 32'(dv_cnt - dv_snap), 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
